// File: rtl/fft_dif_butterfly_pipe_if.sv
// fft_dif_butterfly_pipe_if
// Bundles the butterfly operation stream (input side), the result stream (output side)
// and the overflow flag/clear pair.
//   master : driven by the producer/consumer around the butterfly (e.g. memory sequencer)
//   slave  : the butterfly pipeline itself
// Signals:
//   fft_ifft, in_valid, in_ready, in_scale, in_last, a_*, b_*, tw_*  - operation input
//   out_valid, out_ready, out_last, out0_*, out1_*                   - result output
//   ovf, ovf_clr                                                     - sticky overflow
interface fft_dif_butterfly_pipe_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  fft_ifft;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_scale;
    logic                  in_last;
    logic [DATA_WIDTH-1:0] a_r;
    logic [DATA_WIDTH-1:0] a_i;
    logic [DATA_WIDTH-1:0] b_r;
    logic [DATA_WIDTH-1:0] b_i;
    logic [DATA_WIDTH-1:0] tw_r;
    logic [DATA_WIDTH-1:0] tw_i;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [DATA_WIDTH-1:0] out0_r;
    logic [DATA_WIDTH-1:0] out0_i;
    logic [DATA_WIDTH-1:0] out1_r;
    logic [DATA_WIDTH-1:0] out1_i;
    logic                  ovf;
    logic                  ovf_clr;

    modport master (
        output fft_ifft, in_valid, in_scale, in_last, a_r, a_i, b_r, b_i, tw_r, tw_i,
        output out_ready, ovf_clr,
        input  in_ready, out_valid, out_last, out0_r, out0_i, out1_r, out1_i, ovf
    );

    modport slave (
        input  fft_ifft, in_valid, in_scale, in_last, a_r, a_i, b_r, b_i, tw_r, tw_i,
        input  out_ready, ovf_clr,
        output in_ready, out_valid, out_last, out0_r, out0_i, out1_r, out1_i, ovf
    );
endinterface

// File: rtl/fft_dif_butterfly_pipe.sv
// fft_dif_butterfly_pipe
// Three-stage pipelined radix-2 DIF (Gentleman-Sande) butterfly:
//   out0 = a + b, out1 = (a - b) * W   (W conjugated when fft_ifft = 1)
// S1 add/sub with optional halving, S2 four 32x32 products, S3 combine + round + reduce.
// Whole pipe shifts on advance = !out_valid || out_ready; in_ready = advance.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - fft_dif_butterfly_pipe_if.slave (operation in, result out, ovf / ovf_clr)
// Build option:
//   FFT_DIF_BFLY_SAT_EN - when defined, out-of-range reductions saturate; otherwise they
//                         wrap to the low DATA_WIDTH bits. ovf is set in both builds.
module fft_dif_butterfly_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TW_FRAC    = 30
) (
    input logic                     clk,
    input logic                     rst,
    fft_dif_butterfly_pipe_if.slave bus
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned MW = 2 * DW;      // product width
    localparam int unsigned PW = MW + 1;      // combined product width
    localparam logic [DW-1:0] MAX_VAL = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};
    localparam logic [PW-1:0] RND     = {{(PW-1){1'b0}}, 1'b1} << (TW_FRAC - 1);

    // A (DW+1)-bit sum/diff fits DW bits when its two top bits agree.
    function automatic logic add_ovf(input logic [DW:0] v);
        return v[DW] != v[DW-1];
    endfunction

    function automatic logic [DW-1:0] add_reduce(input logic [DW:0] v, input logic scale);
        logic [DW-1:0] r;
        if (scale) begin
            r = v[DW:1];                      // arithmetic >>1 (floor), never overflows
        end else begin
            r = v[DW-1:0];
`ifdef FFT_DIF_BFLY_SAT_EN
            if (add_ovf(v)) r = v[DW] ? MIN_VAL : MAX_VAL;
`endif
        end
        return r;
    endfunction

    // Shifted product fits DW bits when bits [PW-1:DW-1] are all equal.
    function automatic logic mul_ovf(input logic [PW-1:0] v);
        return !((&v[PW-1:DW-1]) || !(|v[PW-1:DW-1]));
    endfunction

    function automatic logic [DW-1:0] mul_reduce(input logic [PW-1:0] v);
        logic [DW-1:0] r;
        r = v[DW-1:0];
`ifdef FFT_DIF_BFLY_SAT_EN
        if (mul_ovf(v)) r = v[PW-1] ? MIN_VAL : MAX_VAL;
`endif
        return r;
    endfunction

    // Signed DWxDW -> MW product; low MW bits of the sign-extended product are exact.
    function automatic logic [MW-1:0] smul(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [MW-1:0] xe;
        logic [MW-1:0] ye;
        xe = {{DW{x[DW-1]}}, x};
        ye = {{DW{y[DW-1]}}, y};
        return xe * ye;
    endfunction

    logic advance;

    // Stage 1 registers
    logic          v1;
    logic          last1;
    logic [DW-1:0] s1_r, s1_i, d1_r, d1_i, t1_r, t1_i;

    // Stage 2 registers
    logic          v2;
    logic          last2;
    logic [DW-1:0] s2_r, s2_i;
    logic [MW-1:0] p_rr, p_ii, p_ri, p_ir;

    // Output registers
    logic          out_valid_q;
    logic          out_last_q;
    logic [DW-1:0] out0_r_q, out0_i_q, out1_r_q, out1_i_q;
    logic          ovf_q;

    assign advance = !out_valid_q || bus.out_ready;

    // S1 combinational: widened add/sub and conjugation
    logic [DW:0]   sum_r, sum_i, dif_r, dif_i;
    logic [DW-1:0] tw_i_c;
    logic          ovf_s1;

    assign sum_r  = {bus.a_r[DW-1], bus.a_r} + {bus.b_r[DW-1], bus.b_r};
    assign sum_i  = {bus.a_i[DW-1], bus.a_i} + {bus.b_i[DW-1], bus.b_i};
    assign dif_r  = {bus.a_r[DW-1], bus.a_r} - {bus.b_r[DW-1], bus.b_r};
    assign dif_i  = {bus.a_i[DW-1], bus.a_i} - {bus.b_i[DW-1], bus.b_i};
    assign tw_i_c = bus.fft_ifft ? (~bus.tw_i + 1'b1) : bus.tw_i;
    assign ovf_s1 = !bus.in_scale &&
                    (add_ovf(sum_r) || add_ovf(sum_i) || add_ovf(dif_r) || add_ovf(dif_i));

    // S3 combinational: combine, round half up, shift down
    logic [PW-1:0]        pr_full, pi_full;
    logic signed [PW-1:0] pr_sh, pi_sh;
    logic                 ovf_s3;

    assign pr_full = {p_rr[MW-1], p_rr} - {p_ii[MW-1], p_ii} + RND;
    assign pi_full = {p_ri[MW-1], p_ri} + {p_ir[MW-1], p_ir} + RND;
    assign pr_sh   = $signed(pr_full) >>> TW_FRAC;
    assign pi_sh   = $signed(pi_full) >>> TW_FRAC;
    assign ovf_s3  = mul_ovf(pr_sh) || mul_ovf(pi_sh);

    logic ovf_evt;
    assign ovf_evt = advance && ((bus.in_valid && ovf_s1) || (v2 && ovf_s3));

    always_ff @(posedge clk) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out0_r_q    <= '0;
            out0_i_q    <= '0;
            out1_r_q    <= '0;
            out1_i_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (advance) begin
                v1          <= bus.in_valid;
                v2          <= v1;
                out_valid_q <= v2;
                if (v2) begin
                    out_last_q <= last2;
                    out0_r_q   <= s2_r;
                    out0_i_q   <= s2_i;
                    out1_r_q   <= mul_reduce(pr_sh);
                    out1_i_q   <= mul_reduce(pi_sh);
                end
            end
            // A new overflow beats a simultaneous clear.
            ovf_q <= (ovf_q && !bus.ovf_clr) || ovf_evt;
        end
    end

    // Datapath registers without reset; only loaded behind a valid bit.
    always_ff @(posedge clk) begin
        if (advance && bus.in_valid) begin
            last1 <= bus.in_last;
            s1_r  <= add_reduce(sum_r, bus.in_scale);
            s1_i  <= add_reduce(sum_i, bus.in_scale);
            d1_r  <= add_reduce(dif_r, bus.in_scale);
            d1_i  <= add_reduce(dif_i, bus.in_scale);
            t1_r  <= bus.tw_r;
            t1_i  <= tw_i_c;
        end
        if (advance && v1) begin
            last2 <= last1;
            s2_r  <= s1_r;
            s2_i  <= s1_i;
            p_rr  <= smul(d1_r, t1_r);
            p_ii  <= smul(d1_i, t1_i);
            p_ri  <= smul(d1_r, t1_i);
            p_ir  <= smul(d1_i, t1_r);
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out0_r    = out0_r_q;
    assign bus.out0_i    = out0_i_q;
    assign bus.out1_r    = out1_r_q;
    assign bus.out1_i    = out1_i_q;
    assign bus.ovf       = ovf_q;
endmodule
